// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MEM-stage load/store engine.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_RESP = 2'd2,
    MA_DONE = 2'd3
  } ma_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Aligns a bus doubleword to the accessed bytes and sign/zero-extends it to 64 bits.
module load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  addr_lo_i,
  input  logic [7:0]  byte_en_i,
  input  logic        ext_un_i,
  output logic [63:0] data_o
);

  logic [63:0] sh;
  logic        sgn;

  always_comb begin
    sh     = rdata_i >> {addr_lo_i, 3'b000};
    sgn    = ~ext_un_i;
    data_o = sh;
    // Access size comes from the number of enabled lanes, not from their position.
    case (popcount8(byte_en_i))
      4'd1:    data_o = {{56{sgn & sh[7]}},  sh[7:0]};
      4'd2:    data_o = {{48{sgn & sh[15]}}, sh[15:0]};
      4'd4:    data_o = {{32{sgn & sh[31]}}, sh[31:0]};
      default: data_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one valid/ready bus transaction per memory instruction.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        me_inst_valid,
  input  logic        me_mem_rena,
  input  logic        me_mem_wena,
  input  logic        me_mem_ext_un,
  input  logic [7:0]  me_mem_byte_enable,
  input  logic [63:0] me_alu_result,
  input  logic [63:0] me_new_rs2_data,
  input  logic        me_exception_flag,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata,
  output logic        mem_stall_req,
  output logic        mem_done,
  output logic        mem_fault,
  output logic [63:0] mem_rdata
);

  ma_state_e        state_q;
  logic             req_valid_q, req_wen_q, done_q, fault_q, stale_q;
  logic [63:0]      req_addr_q, req_wdata_q, rdata_q;
  logic [7:0]       req_wstrb_q, be_q;
  logic [2:0]       addr_lo_q;
  logic             ext_un_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      fmt_d;
  logic             pending, drop;

  assign pending = me_inst_valid & (me_mem_rena | me_mem_wena) & ~me_exception_flag;
  // A flush seen at any point of the transaction, including its last cycle, discards the result.
  assign drop    = stale_q | ~pending;

  load_formatter u_fmt (
    .rdata_i   (mem_resp_rdata),
    .addr_lo_i (addr_lo_q),
    .byte_en_i (be_q),
    .ext_un_i  (ext_un_q),
    .data_o    (fmt_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MA_IDLE;
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      stale_q     <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        MA_IDLE: begin
          if (pending) begin
            // Request fields are captured so a flushed slot cannot disturb the bus.
            state_q     <= MA_REQ;
            req_valid_q <= 1'b1;
            stale_q     <= 1'b0;
            req_addr_q  <= {me_alu_result[63:3], 3'b000};
            req_wen_q   <= me_mem_wena;
            req_wdata_q <= me_new_rs2_data << {me_alu_result[2:0], 3'b000};
            req_wstrb_q <= me_mem_wena ? me_mem_byte_enable : 8'h00;
            addr_lo_q   <= me_alu_result[2:0];
            be_q        <= me_mem_byte_enable;
            ext_un_q    <= me_mem_ext_un;
          end
        end
        MA_REQ: begin
          if (!pending) stale_q <= 1'b1;
          if (mem_req_ready) begin
            state_q     <= MA_RESP;
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        MA_RESP: begin
          if (!pending) stale_q <= 1'b1;
          if (mem_resp_valid) begin
            if (drop) begin
              state_q <= MA_IDLE;
            end else begin
              state_q <= MA_DONE;
              done_q  <= 1'b1;
              if (!req_wen_q) rdata_q <= fmt_d;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            if (drop) begin
              state_q <= MA_IDLE;
            end else begin
              state_q <= MA_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              rdata_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        MA_DONE: state_q <= MA_IDLE;
        default: state_q <= MA_IDLE;
      endcase
    end
  end

  assign mem_stall_req = pending & (state_q != MA_DONE);
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wstrb = req_wstrb_q;
  assign mem_done      = done_q;
  assign mem_fault     = fault_q;
  assign mem_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit and its standalone load formatter.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        me_inst_valid, me_mem_rena, me_mem_wena, me_mem_ext_un, me_exception_flag;
  logic [7:0]  me_mem_byte_enable;
  logic [63:0] me_alu_result, me_new_rs2_data;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        mem_stall_req, mem_done, mem_fault;
  logic [63:0] mem_rdata;

  logic [63:0] lf_rdata, lf_out;
  logic [2:0]  lf_addr;
  logic [7:0]  lf_be;
  logic        lf_ext;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(256), .CNT_W(9)) dut (
    .clk(clk), .rst(rst),
    .me_inst_valid(me_inst_valid), .me_mem_rena(me_mem_rena), .me_mem_wena(me_mem_wena),
    .me_mem_ext_un(me_mem_ext_un), .me_mem_byte_enable(me_mem_byte_enable),
    .me_alu_result(me_alu_result), .me_new_rs2_data(me_new_rs2_data),
    .me_exception_flag(me_exception_flag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_stall_req(mem_stall_req), .mem_done(mem_done), .mem_fault(mem_fault),
    .mem_rdata(mem_rdata)
  );

  load_formatter u_lf (
    .rdata_i(lf_rdata), .addr_lo_i(lf_addr), .byte_en_i(lf_be), .ext_un_i(lf_ext), .data_o(lf_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic slot(input logic rena, input logic wena, input logic ext,
                      input logic [7:0] be, input logic [63:0] addr, input logic [63:0] rs2);
    me_inst_valid      = 1'b1;
    me_mem_rena        = rena;
    me_mem_wena        = wena;
    me_mem_ext_un      = ext;
    me_mem_byte_enable = be;
    me_alu_result      = addr;
    me_new_rs2_data    = rs2;
    me_exception_flag  = 1'b0;
  endtask

  // IDLE -> REQ -> RESP with a ready bus; leaves the DUT in its first RESP cycle.
  task automatic go_to_resp();
    cyc();
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [63:0] data);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = data;
    cyc();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    me_inst_valid = 1'b0; me_mem_rena = 1'b0; me_mem_wena = 1'b0; me_mem_ext_un = 1'b0;
    me_mem_byte_enable = 8'h00; me_alu_result = '0; me_new_rs2_data = '0; me_exception_flag = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    lf_rdata = '0; lf_addr = 3'd0; lf_be = 8'h00; lf_ext = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_req_valid", mem_req_valid, 64'd0);
    chk("rst_done",      mem_done,      64'd0);
    chk("rst_fault",     mem_fault,     64'd0);
    chk("rst_rdata",     mem_rdata,     64'd0);
    chk("rst_stall",     mem_stall_req, 64'd0);

    // Older exception suppresses the access entirely.
    slot(1'b1, 1'b0, 1'b0, 8'hFF, 64'h100, 64'd0);
    me_exception_flag = 1'b1;
    #1 chk("exc_stall", mem_stall_req, 64'd0);
    cyc();
    chk("exc_req_valid", mem_req_valid, 64'd0);
    me_inst_valid = 1'b0; me_exception_flag = 1'b0;

    // LB 0x1003, sign-extended, zero-wait bus.
    slot(1'b1, 1'b0, 1'b0, 8'h08, 64'h1003, 64'd0);
    #1 chk("lb_stall_idle", mem_stall_req, 64'd1);
    cyc();
    chk("lb_req_valid", mem_req_valid, 64'd1);
    chk("lb_req_addr",  mem_req_addr,  64'h1000);
    chk("lb_req_wen",   mem_req_wen,   64'd0);
    chk("lb_req_wstrb", mem_req_wstrb, 64'h00);
    chk("lb_stall_req", mem_stall_req, 64'd1);
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    chk("lb_resp_valid_low", mem_req_valid, 64'd0);
    chk("lb_stall_resp",     mem_stall_req, 64'd1);
    respond(64'h0000_0000_8000_0000);
    chk("lb_done",  mem_done,      64'd1);
    chk("lb_fault", mem_fault,     64'd0);
    chk("lb_rdata", mem_rdata,     64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_stall_done", mem_stall_req, 64'd0);
    me_inst_valid = 1'b0;
    cyc();
    chk("lb_done_pulse", mem_done, 64'd0);

    // LHU 0x2006
    slot(1'b1, 1'b0, 1'b1, 8'hC0, 64'h2006, 64'd0);
    go_to_resp();
    respond(64'hBEEF_0000_0000_0000);
    chk("lhu_done",  mem_done,  64'd1);
    chk("lhu_rdata", mem_rdata, 64'h0000_0000_0000_BEEF);
    me_inst_valid = 1'b0;
    cyc();

    // LW 0x6004, sign-extended
    slot(1'b1, 1'b0, 1'b0, 8'hF0, 64'h6004, 64'd0);
    go_to_resp();
    respond(64'h8000_0001_0000_0000);
    chk("lw_rdata", mem_rdata, 64'hFFFF_FFFF_8000_0001);
    me_inst_valid = 1'b0;
    cyc();

    // SW 0x3004 with ready held low for 5 cycles.
    slot(1'b0, 1'b1, 1'b0, 8'hF0, 64'h3004, 64'h1122_3344);
    #1 chk("sw_stall_idle", mem_stall_req, 64'd1);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("sw_req_valid", mem_req_valid, 64'd1);
      chk("sw_req_addr",  mem_req_addr,  64'h3000);
      chk("sw_req_wdata", mem_req_wdata, 64'h1122_3344_0000_0000);
      chk("sw_req_wstrb", mem_req_wstrb, 64'hF0);
      chk("sw_req_wen",   mem_req_wen,   64'd1);
      chk("sw_stall",     mem_stall_req, 64'd1);
      cyc();
    end
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    respond(64'hDEAD_BEEF_DEAD_BEEF);
    chk("sw_done",  mem_done,  64'd1);
    chk("sw_fault", mem_fault, 64'd0);
    chk("sw_rdata_kept", mem_rdata, 64'hFFFF_FFFF_8000_0001);
    me_inst_valid = 1'b0;
    cyc();

    // Watchdog: no response at all.
    slot(1'b1, 1'b0, 1'b0, 8'hFF, 64'h4000, 64'd0);
    go_to_resp();
    n = 0;
    while (!mem_done && n < 300) begin
      cyc();
      n++;
    end
    chk("to_cycles", 64'(n), 64'd256);
    chk("to_done",   mem_done,      64'd1);
    chk("to_fault",  mem_fault,     64'd1);
    chk("to_rdata",  mem_rdata,     64'd0);
    chk("to_stall",  mem_stall_req, 64'd0);
    me_inst_valid = 1'b0;
    cyc();
    chk("to_fault_pulse", mem_fault, 64'd0);

    // Flush mid-RESP: transaction completes silently.
    slot(1'b1, 1'b0, 1'b0, 8'hFF, 64'h5000, 64'd0);
    go_to_resp();
    me_inst_valid = 1'b0;
    respond(64'h1234);
    chk("flush_done",  mem_done,  64'd0);
    chk("flush_rdata", mem_rdata, 64'd0);
    cyc();
    chk("flush_done2", mem_done,  64'd0);

    // Next access proves the FSM returned to IDLE: LBU 0x7007.
    slot(1'b1, 1'b0, 1'b1, 8'h80, 64'h7007, 64'd0);
    cyc();
    chk("lbu_req_valid", mem_req_valid, 64'd1);
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    respond(64'hAB00_0000_0000_0000);
    chk("lbu_rdata", mem_rdata, 64'h0000_0000_0000_00AB);
    me_inst_valid = 1'b0;
    cyc();

    // Reset while in RESP, then stray response beats.
    slot(1'b1, 1'b0, 1'b0, 8'hFF, 64'h8000, 64'd0);
    go_to_resp();
    rst = 1'b1;
    me_inst_valid = 1'b0;
    cyc();
    rst = 1'b0;
    chk("rrst_req_valid", mem_req_valid, 64'd0);
    chk("rrst_done",      mem_done,      64'd0);
    chk("rrst_rdata",     mem_rdata,     64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h5555_5555_5555_5555;
    cyc(); cyc();
    mem_resp_valid = 1'b0;
    chk("stray_done",      mem_done,      64'd0);
    chk("stray_req_valid", mem_req_valid, 64'd0);
    chk("stray_rdata",     mem_rdata,     64'd0);

    // Standalone formatter vectors.
    lf_rdata = 64'hF000_0000_0000_0000; lf_addr = 3'd7; lf_be = 8'h80; lf_ext = 1'b1;
    #1 chk("lf_lbu", lf_out, 64'h0000_0000_0000_00F0);
    lf_ext = 1'b0;
    #1 chk("lf_lb", lf_out, 64'hFFFF_FFFF_FFFF_FFF0);
    lf_rdata = 64'h0000_0000_8001_0000; lf_addr = 3'd2; lf_be = 8'h0C; lf_ext = 1'b0;
    #1 chk("lf_lh", lf_out, 64'hFFFF_FFFF_FFFF_8001);
    lf_rdata = 64'h8123_4567_89AB_CDEF; lf_addr = 3'd0; lf_be = 8'hFF; lf_ext = 1'b1;
    #1 chk("lf_ld", lf_out, 64'h8123_4567_89AB_CDEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
